// File: rtl/goertzel_bin_scheduler.sv
// Purpose: time-shares one Goertzel magnitude engine across NUM_BINS bins per frame and reports detections.
// Latency: frame_rdy -> eng_start 1 cycle; eng_mag_rdy -> next eng_start (or det_valid) 2 cycles.
// Backpressure: none; one extra frame queues as pending, any further frame_rdy sets sticky overrun.
// Ports: sys_clk/rst_n clock and async active-low reset; en master enable; frame_rdy frame-available pulse;
//        cfg_* per-bin coefficient/threshold table write; eng_* engine start/coef/result handshake;
//        buf_release frame-buffer return; det_* detection bitmap and peak report; busy/overrun/timeout status.
module goertzel_bin_scheduler #(
  parameter int NUM_BINS = 4,
  parameter int BIN_BITS = 2,
  parameter int C_W      = 16,
  parameter int M_W      = 16,
  parameter int TO_BITS  = 16
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                frame_rdy,
  input  logic                cfg_we,
  input  logic [BIN_BITS-1:0] cfg_addr,
  input  logic [C_W-1:0]      cfg_coef,
  input  logic [M_W-1:0]      cfg_thresh,
  output logic                eng_start,
  output logic [C_W-1:0]      eng_coef,
  input  logic                eng_mag_rdy,
  input  logic [M_W-1:0]      eng_mag,
  output logic                buf_release,
  output logic                det_valid,
  output logic [NUM_BINS-1:0] det_bitmap,
  output logic [BIN_BITS-1:0] peak_bin,
  output logic [M_W-1:0]      peak_mag,
  output logic                busy,
  output logic                overrun,
  output logic                timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_EVAL,
    S_DONE
  } state_t;

  localparam logic [BIN_BITS-1:0] LAST_BIN = BIN_BITS'(NUM_BINS - 1);
  // The watchdog is checked one count early so that exactly 2^TO_BITS-1 WAIT cycles elapse.
  localparam logic [TO_BITS-1:0]  WD_LAST  = {{(TO_BITS-1){1'b1}}, 1'b0};

  // Per-bin configuration table
  logic [C_W-1:0] coef_q   [NUM_BINS];
  logic [M_W-1:0] thresh_q [NUM_BINS];

  state_t               state_q, state_d;
  logic [BIN_BITS-1:0]  bin_q, bin_d;
  logic                 pending_q, pending_d;
  logic [TO_BITS-1:0]   wd_q, wd_d;
  logic [M_W-1:0]       mag_q, mag_d;
  logic [NUM_BINS-1:0]  work_bitmap_q, work_bitmap_d;
  logic [M_W-1:0]       work_peak_q, work_peak_d;
  logic [BIN_BITS-1:0]  work_bin_q, work_bin_d;

  logic                 eng_start_q, eng_start_d;
  logic [C_W-1:0]       eng_coef_q, eng_coef_d;
  logic                 buf_release_q, buf_release_d;
  logic                 det_valid_q, det_valid_d;
  logic [NUM_BINS-1:0]  det_bitmap_q, det_bitmap_d;
  logic [BIN_BITS-1:0]  peak_bin_q, peak_bin_d;
  logic [M_W-1:0]       peak_mag_q, peak_mag_d;
  logic                 busy_q, busy_d;
  logic                 overrun_q, overrun_d;
  logic                 timeout_q, timeout_d;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BINS; i++) begin
        coef_q[i]   <= '0;
        thresh_q[i] <= '1;
      end
    end else if (cfg_we) begin
      coef_q[cfg_addr]   <= cfg_coef;
      thresh_q[cfg_addr] <= cfg_thresh;
    end
  end

  always_comb begin
    state_d       = state_q;
    bin_d         = bin_q;
    pending_d     = pending_q;
    wd_d          = wd_q;
    mag_d         = mag_q;
    work_bitmap_d = work_bitmap_q;
    work_peak_d   = work_peak_q;
    work_bin_d    = work_bin_q;
    eng_start_d   = 1'b0;
    eng_coef_d    = eng_coef_q;
    buf_release_d = 1'b0;
    det_valid_d   = 1'b0;
    det_bitmap_d  = det_bitmap_q;
    peak_bin_d    = peak_bin_q;
    peak_mag_d    = peak_mag_q;
    overrun_d     = overrun_q;
    timeout_d     = timeout_q;

    // A frame arriving while a frame is in flight is queued once; a second one is dropped.
    if (frame_rdy && (state_q != S_IDLE)) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (frame_rdy || pending_q) begin
          state_d       = S_START;
          // Starting the queued frame while a new one arrives keeps the new one queued.
          pending_d     = pending_q & frame_rdy;
          bin_d         = '0;
          work_bitmap_d = '0;
          work_peak_d   = '0;
          work_bin_d    = '0;
        end
      end
      S_START: begin
        state_d = S_WAIT;
        wd_d    = '0;
      end
      S_WAIT: begin
        // A result arriving on the terminal watchdog cycle still counts.
        if (eng_mag_rdy) begin
          mag_d   = eng_mag;
          state_d = S_EVAL;
        end else if (wd_q == WD_LAST) begin
          timeout_d     = 1'b1;
          buf_release_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_EVAL: begin
        work_bitmap_d[bin_q] = (mag_q >= thresh_q[bin_q]);
        // Strict compare so ties keep the lowest bin index.
        if ((bin_q == '0) || (mag_q > work_peak_q)) begin
          work_peak_d = mag_q;
          work_bin_d  = bin_q;
        end
        if (bin_q == LAST_BIN) begin
          state_d       = S_DONE;
          det_valid_d   = 1'b1;
          buf_release_d = 1'b1;
          det_bitmap_d  = work_bitmap_d;
          peak_bin_d    = work_bin_d;
          peak_mag_d    = work_peak_d;
        end else begin
          bin_d   = bin_q + 1'b1;
          state_d = S_START;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Disable aborts the frame but leaves the last report visible.
    if (!en) begin
      state_d       = S_IDLE;
      pending_d     = 1'b0;
      overrun_d     = 1'b0;
      timeout_d     = 1'b0;
      buf_release_d = 1'b0;
      det_valid_d   = 1'b0;
      det_bitmap_d  = det_bitmap_q;
      peak_bin_d    = peak_bin_q;
      peak_mag_d    = peak_mag_q;
    end

    // Coefficient is captured on entry to START so it is valid alongside eng_start;
    // a table write on that same edge is forwarded so it is not missed.
    if (state_d == S_START) begin
      eng_start_d = 1'b1;
      eng_coef_d  = (cfg_we && (cfg_addr == bin_d)) ? cfg_coef : coef_q[bin_d];
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      bin_q         <= '0;
      pending_q     <= 1'b0;
      wd_q          <= '0;
      mag_q         <= '0;
      work_bitmap_q <= '0;
      work_peak_q   <= '0;
      work_bin_q    <= '0;
      eng_start_q   <= 1'b0;
      eng_coef_q    <= '0;
      buf_release_q <= 1'b0;
      det_valid_q   <= 1'b0;
      det_bitmap_q  <= '0;
      peak_bin_q    <= '0;
      peak_mag_q    <= '0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      bin_q         <= bin_d;
      pending_q     <= pending_d;
      wd_q          <= wd_d;
      mag_q         <= mag_d;
      work_bitmap_q <= work_bitmap_d;
      work_peak_q   <= work_peak_d;
      work_bin_q    <= work_bin_d;
      eng_start_q   <= eng_start_d;
      eng_coef_q    <= eng_coef_d;
      buf_release_q <= buf_release_d;
      det_valid_q   <= det_valid_d;
      det_bitmap_q  <= det_bitmap_d;
      peak_bin_q    <= peak_bin_d;
      peak_mag_q    <= peak_mag_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
      timeout_q     <= timeout_d;
    end
  end

  // Gate with en so a start pulse never coincides with the disable cycle.
  assign eng_start   = eng_start_q & en;
  assign eng_coef    = eng_coef_q;
  assign buf_release = buf_release_q;
  assign det_valid   = det_valid_q;
  assign det_bitmap  = det_bitmap_q;
  assign peak_bin    = peak_bin_q;
  assign peak_mag    = peak_mag_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_goertzel_bin_scheduler.sv
module tb_goertzel_bin_scheduler;

  localparam int NUM_BINS = 4;
  localparam int BIN_BITS = 2;
  localparam int C_W      = 16;
  localparam int M_W      = 16;
  localparam int TO_BITS  = 4;
  localparam int ENG_LAT  = 10;

  logic                sys_clk;
  logic                rst_n;
  logic                en;
  logic                frame_rdy;
  logic                cfg_we;
  logic [BIN_BITS-1:0] cfg_addr;
  logic [C_W-1:0]      cfg_coef;
  logic [M_W-1:0]      cfg_thresh;
  logic                eng_start;
  logic [C_W-1:0]      eng_coef;
  logic                eng_mag_rdy;
  logic [M_W-1:0]      eng_mag;
  logic                buf_release;
  logic                det_valid;
  logic [NUM_BINS-1:0] det_bitmap;
  logic [BIN_BITS-1:0] peak_bin;
  logic [M_W-1:0]      peak_mag;
  logic                busy;
  logic                overrun;
  logic                timeout;

  goertzel_bin_scheduler #(
    .NUM_BINS(NUM_BINS), .BIN_BITS(BIN_BITS), .C_W(C_W), .M_W(M_W), .TO_BITS(TO_BITS)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .en(en), .frame_rdy(frame_rdy),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_coef(cfg_coef), .cfg_thresh(cfg_thresh),
    .eng_start(eng_start), .eng_coef(eng_coef), .eng_mag_rdy(eng_mag_rdy), .eng_mag(eng_mag),
    .buf_release(buf_release), .det_valid(det_valid), .det_bitmap(det_bitmap),
    .peak_bin(peak_bin), .peak_mag(peak_mag), .busy(busy), .overrun(overrun), .timeout(timeout)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Engine model: answers mag_tbl[bin] ENG_LAT cycles after eng_start; bin comes from the coefficient's low bits.
  logic [M_W-1:0] mag_tbl [NUM_BINS];
  bit             eng_hold = 1'b0;

  initial begin
    logic [BIN_BITS-1:0] b;
    eng_mag_rdy = 1'b0;
    eng_mag     = '0;
    forever begin
      @(posedge sys_clk); #1;
      if (eng_start && !eng_hold) begin
        b = eng_coef[BIN_BITS-1:0];
        repeat (ENG_LAT) @(posedge sys_clk);
        #1;
        eng_mag_rdy = 1'b1;
        eng_mag     = mag_tbl[b];
        @(posedge sys_clk); #1;
        eng_mag_rdy = 1'b0;
      end
    end
  end

  // Event monitor sampled on the falling edge.
  int            cyc = 0;
  int            n_start = 0, n_rdy = 0, n_det = 0, n_rel = 0;
  int            start_cyc [256];
  int            rdy_cyc   [256];
  logic [C_W-1:0] coef_log [256];
  int            det_lat = -1, rel_cyc = -1;
  int            en_viol = 0, det_wo_rel = 0;

  always @(negedge sys_clk) begin
    cyc++;
    if (eng_start) begin
      start_cyc[n_start & 255] = cyc;
      coef_log[n_start & 255]  = eng_coef;
      n_start++;
      if (!en) en_viol++;
    end
    if (eng_mag_rdy) begin
      rdy_cyc[n_rdy & 255] = cyc;
      n_rdy++;
    end
    if (det_valid) begin
      n_det++;
      det_lat = cyc - rdy_cyc[(n_rdy - 1) & 255];
      if (!buf_release) det_wo_rel++;
    end
    if (buf_release) begin
      n_rel++;
      rel_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge sys_clk); #1;
  endtask

  task automatic sample();
    @(negedge sys_clk); #1;
  endtask

  task automatic cfg_write(input int bin, input int coef, input int thr);
    tick();
    cfg_we     = 1'b1;
    cfg_addr   = BIN_BITS'(bin);
    cfg_coef   = C_W'(coef);
    cfg_thresh = M_W'(thr);
    tick();
    cfg_we     = 1'b0;
  endtask

  task automatic pulse_frame();
    tick();
    frame_rdy = 1'b1;
    tick();
    frame_rdy = 1'b0;
  endtask

  // sel: 0 = det_valid count, 1 = eng_start count, 2 = buf_release count
  task automatic wait_count(input int sel, input int target, input int budget, output bit found);
    int v;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      sample();
      v = (sel == 0) ? n_det : (sel == 1) ? n_start : n_rel;
      if (v >= target) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic set_mags(input int m0, input int m1, input int m2, input int m3);
    mag_tbl[0] = M_W'(m0);
    mag_tbl[1] = M_W'(m1);
    mag_tbl[2] = M_W'(m2);
    mag_tbl[3] = M_W'(m3);
  endtask

  initial begin
    bit found;
    int sb, rb, db, relb;

    rst_n = 1'b0; en = 1'b1; frame_rdy = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_coef = '0; cfg_thresh = '0;
    set_mags(150, 150, 500, 50);

    // Reset state
    repeat (2) sample();
    check_eq("rst_outs", {det_bitmap, peak_bin, peak_mag, busy, overrun, timeout,
                          eng_start, det_valid, buf_release, eng_coef}, 64'd0);
    tick();
    rst_n = 1'b1;

    // Basic frame: thresholds 100/200/300/400, magnitudes 150/150/500/50
    for (int i = 0; i < NUM_BINS; i++) cfg_write(i, 16'hC000 + i, 100 * (i + 1));
    sb = n_start; rb = n_rdy; relb = n_rel;
    pulse_frame();
    sample();
    check_eq("t1_start_lat", eng_start, 1'b1);
    check_eq("t1_busy", busy, 1'b1);
    wait_count(0, n_det + 1, 300, found);
    check_eq("t1_det_seen", found, 1'b1);
    check_eq("t1_bitmap", det_bitmap, 4'b0101);
    check_eq("t1_peak_bin", peak_bin, 2'd2);
    check_eq("t1_peak_mag", peak_mag, 16'd500);
    check_eq("t1_release", buf_release, 1'b1);
    check_eq("t1_det_lat", det_lat, 2);
    check_eq("t1_next_start_lat", start_cyc[(sb + 1) & 255] - rdy_cyc[rb & 255], 2);
    check_eq("t1_starts", n_start - sb, 4);
    for (int i = 0; i < NUM_BINS; i++) check_eq($sformatf("t1_coef%0d", i), coef_log[(sb + i) & 255], 16'hC000 + i);
    sample();
    check_eq("t1_det_pulse_len", det_valid, 1'b0);
    check_eq("t1_rel_count", n_rel - relb, 1);

    // Equal magnitudes: tie keeps bin 0, threshold equality sets the bit
    cfg_write(1, 16'hC001, 300);
    set_mags(300, 300, 300, 300);
    pulse_frame();
    wait_count(0, n_det + 1, 300, found);
    check_eq("t2_det_seen", found, 1'b1);
    check_eq("t2_bitmap", det_bitmap, 4'b0111);
    check_eq("t2_peak_bin", peak_bin, 2'd0);
    check_eq("t2_peak_mag", peak_mag, 16'd300);

    // Pending and overrun: three frame_rdy pulses, two frames processed
    set_mags(150, 150, 500, 50);
    db = n_det; relb = n_rel;
    pulse_frame();
    repeat (5) tick();
    pulse_frame();
    repeat (5) tick();
    check_eq("t3_overrun_before", overrun, 1'b0);
    pulse_frame();
    wait_count(0, db + 2, 400, found);
    check_eq("t3_two_dets", found, 1'b1);
    repeat (40) sample();
    check_eq("t3_det_count", n_det - db, 2);
    check_eq("t3_rel_count", n_rel - relb, 2);
    check_eq("t3_overrun", overrun, 1'b1);
    check_eq("t3_bitmap", det_bitmap, 4'b0101);
    check_eq("t3_idle", busy, 1'b0);

    // Disable during WAIT of bin 2
    sb = n_start;
    pulse_frame();
    wait_count(1, sb + 3, 200, found);
    check_eq("t4_bin2_start", found, 1'b1);
    db = n_det; relb = n_rel;
    tick(); tick();
    en = 1'b0;
    tick();
    sample();
    check_eq("t4_idle_next", busy, 1'b0);
    check_eq("t4_overrun_clr", overrun, 1'b0);
    repeat (20) tick();
    sample();
    check_eq("t4_no_det", n_det - db, 0);
    check_eq("t4_no_rel", n_rel - relb, 0);
    check_eq("t4_det_held", {det_bitmap, peak_bin, peak_mag}, {4'b0101, 2'd2, 16'd500});
    en = 1'b1;
    sb = n_start;
    pulse_frame();
    wait_count(0, n_det + 1, 300, found);
    check_eq("t4_restart_det", found, 1'b1);
    check_eq("t4_restart_coef0", coef_log[sb & 255], 16'hC000);
    check_eq("t4_restart_bitmap", det_bitmap, 4'b0101);

    // Engine timeout
    eng_hold = 1'b1;
    db = n_det; relb = n_rel; sb = n_start;
    pulse_frame();
    wait_count(2, relb + 1, 100, found);
    check_eq("t5_release_seen", found, 1'b1);
    check_eq("t5_timeout", timeout, 1'b1);
    check_eq("t5_wait_len", rel_cyc - start_cyc[sb & 255], 16);
    check_eq("t5_no_det", n_det - db, 0);
    eng_hold = 1'b0;
    repeat (3) tick();
    pulse_frame();
    wait_count(0, n_det + 1, 300, found);
    check_eq("t5_next_det", found, 1'b1);
    check_eq("t5_next_bitmap", det_bitmap, 4'b0101);
    check_eq("t5_timeout_sticky", timeout, 1'b1);

    // Asynchronous reset in the middle of WAIT
    sb = n_start;
    pulse_frame();
    wait_count(1, sb + 1, 50, found);
    check_eq("t6_started", found, 1'b1);
    tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_async_outs", {det_bitmap, peak_bin, peak_mag, busy, overrun, timeout,
                               eng_start, det_valid, buf_release, eng_coef}, 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    set_mags(16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE);
    pulse_frame();
    sample();
    check_eq("t6_coef_cleared", {eng_start, eng_coef}, {1'b1, 16'h0000});
    wait_count(0, n_det + 1, 300, found);
    check_eq("t6_det_seen", found, 1'b1);
    check_eq("t6_bitmap", det_bitmap, 4'b0000);
    check_eq("t6_peak", {peak_bin, peak_mag}, {2'd0, 16'hFFFE});

    check_eq("en_low_start", en_viol, 0);
    check_eq("det_without_rel", det_wo_rel, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
